// File: rtl/aes_job_sched.sv
// aes_job_sched: shares one AES_ENC / AES_DEC core pair between two requesters.
//
// Requesters raise REQn (level) with MODEn/KEYn/DINn; a round-robin arbiter
// grants one (GNTn pulses while the inputs are captured), the scheduler runs
// the Krdy -> Drdy -> Dvld handshake on the selected core, and returns the
// result on DOUT/ERR with a RESP_VLDn / RESP_RDYn handshake. A watchdog aborts
// a job whose core never raises Dvld (ERR = 1, DOUT = 0).
//
// Ports:
//   CLK, RST                   clock, asynchronous active-high reset
//   REQn, MODEn, KEYn, DINn    job request and operands (n = 0, 1)
//   GNTn                       grant pulse
//   RESP_VLDn, RESP_RDYn       response handshake, DOUT/ERR shared
//   C_KEY, C_DIN, C_KRDY, C_DRDY, C_EN_E, C_EN_D   drive the core pair
//   C_BSY_x, C_DVLD_x, C_DOUT_x                     core status/results
//
// Optional feature (macro AES_KEY_CACHE_EN): remember {mode, key} of the last
// successful job and skip the KEY step when the next job reuses it.
module aes_job_sched #(
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned RST_PTR = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ0,
  input  logic         REQ1,
  input  logic         MODE0,
  input  logic         MODE1,
  input  logic [127:0] KEY0,
  input  logic [127:0] KEY1,
  input  logic [127:0] DIN0,
  input  logic [127:0] DIN1,
  output logic         GNT0,
  output logic         GNT1,
  output logic         RESP_VLD0,
  output logic         RESP_VLD1,
  input  logic         RESP_RDY0,
  input  logic         RESP_RDY1,
  output logic [127:0] DOUT,
  output logic         ERR,
  output logic [127:0] C_KEY,
  output logic [127:0] C_DIN,
  output logic         C_KRDY,
  output logic         C_DRDY,
  output logic         C_EN_E,
  output logic         C_EN_D,
  input  logic         C_BSY_E,
  input  logic         C_BSY_D,
  input  logic         C_DVLD_E,
  input  logic         C_DVLD_D,
  input  logic [127:0] C_DOUT_E,
  input  logic [127:0] C_DOUT_D
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

  typedef enum logic [2:0] {StIdle, StKey, StData, StWait, StDone} state_e;

  state_e         state_q, state_d;
  logic           ptr_q, ptr_d;
  logic           owner_q, owner_d;
  logic           mode_q, mode_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   din_q, din_d;
  logic [127:0]   dout_q, dout_d;
  logic           err_q, err_d;
  logic [WdW-1:0] wd_q, wd_d, wd_inc;
  logic           krdy_q, krdy_d;
  logic           en_e_q, en_e_d;
  logic           en_d_q, en_d_d;
  logic           vld0_q, vld0_d;
  logic           vld1_q, vld1_d;

  logic           gnt0_c, gnt1_c, act_d;
  logic           req_mode, cache_hit;
  logic [127:0]   req_key;
  logic           bsy_sel, dvld_sel;
  logic [127:0]   dout_sel;

  // Round-robin: a lone request wins; on contention the pointer decides.
  assign gnt0_c   = REQ0 & (~REQ1 | ~ptr_q);
  assign gnt1_c   = REQ1 & (~REQ0 | ptr_q);
  assign req_mode = gnt1_c ? MODE1 : MODE0;
  assign req_key  = gnt1_c ? KEY1 : KEY0;

  assign bsy_sel  = mode_q ? C_BSY_D : C_BSY_E;
  assign dvld_sel = mode_q ? C_DVLD_D : C_DVLD_E;
  assign dout_sel = mode_q ? C_DOUT_D : C_DOUT_E;
  assign wd_inc   = wd_q + 1'b1;

`ifdef AES_KEY_CACHE_EN
  logic         cache_vld_q, cache_vld_d;
  logic         cache_mode_q, cache_mode_d;
  logic [127:0] cache_key_q, cache_key_d;
  assign cache_hit = cache_vld_q & (req_mode == cache_mode_q) & (req_key == cache_key_q);
`else
  assign cache_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    mode_d  = mode_q;
    key_d   = key_q;
    din_d   = din_q;
    dout_d  = dout_q;
    err_d   = err_q;
    wd_d    = wd_q;
    GNT0    = 1'b0;
    GNT1    = 1'b0;
`ifdef AES_KEY_CACHE_EN
    cache_vld_d  = cache_vld_q;
    cache_mode_d = cache_mode_q;
    cache_key_d  = cache_key_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (gnt0_c | gnt1_c) begin
          GNT0    = gnt0_c;
          GNT1    = gnt1_c;
          owner_d = gnt1_c;
          mode_d  = req_mode;
          key_d   = req_key;
          din_d   = gnt1_c ? DIN1 : DIN0;
          state_d = cache_hit ? StData : StKey;
        end
      end
      StKey:  state_d = StData;
      StData: begin
        if (!bsy_sel) begin
          wd_d    = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        wd_d = wd_inc;
        // Dvld takes precedence over a timeout landing in the same cycle.
        if (dvld_sel) begin
          dout_d  = dout_sel;
          err_d   = 1'b0;
          state_d = StDone;
`ifdef AES_KEY_CACHE_EN
          cache_vld_d  = 1'b1;
          cache_mode_d = mode_q;
          cache_key_d  = key_q;
`endif
        end else if (wd_inc == WdMax) begin
          dout_d  = '0;
          err_d   = 1'b1;
          state_d = StDone;
`ifdef AES_KEY_CACHE_EN
          cache_vld_d = 1'b0;
`endif
        end
      end
      StDone: begin
        if (owner_q ? RESP_RDY1 : RESP_RDY0) begin
          ptr_d   = ~owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Handshake outputs are registered from the next state.
    act_d  = (state_d == StKey) | (state_d == StData) | (state_d == StWait);
    krdy_d = (state_d == StKey);
    en_e_d = act_d & ~mode_d;
    en_d_d = act_d & mode_d;
    vld0_d = (state_d == StDone) & ~owner_d;
    vld1_d = (state_d == StDone) & owner_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      ptr_q   <= 1'(RST_PTR);
      owner_q <= 1'b0;
      mode_q  <= 1'b0;
      key_q   <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
      krdy_q  <= 1'b0;
      en_e_q  <= 1'b0;
      en_d_q  <= 1'b0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
`ifdef AES_KEY_CACHE_EN
      cache_vld_q  <= 1'b0;
      cache_mode_q <= 1'b0;
      cache_key_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      mode_q  <= mode_d;
      key_q   <= key_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
      krdy_q  <= krdy_d;
      en_e_q  <= en_e_d;
      en_d_q  <= en_d_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
`ifdef AES_KEY_CACHE_EN
      cache_vld_q  <= cache_vld_d;
      cache_mode_q <= cache_mode_d;
      cache_key_q  <= cache_key_d;
`endif
    end
  end

  assign C_KEY     = key_q;
  assign C_DIN     = din_q;
  assign C_KRDY    = krdy_q;
  // Drdy must react to Busy in the same cycle, so it stays combinational.
  assign C_DRDY    = (state_q == StData) & ~bsy_sel;
  assign C_EN_E    = en_e_q;
  assign C_EN_D    = en_d_q;
  assign RESP_VLD0 = vld0_q;
  assign RESP_VLD1 = vld1_q;
  assign DOUT      = dout_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_aes_job_sched.sv
// Bench for aes_job_sched: behavioural core-pair model, scoreboard of expected
// responses, table of jobs plus hand-written multi-cycle sequences.
module tb_aes_job_sched;
  localparam int unsigned TO  = 32;
  localparam int          LAT = 4;

  localparam logic [127:0] KF = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PF = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CF = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KD = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] D2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  logic CLK = 1'b0, RST = 1'b1;
  logic REQ0, REQ1, MODE0, MODE1, GNT0, GNT1, RESP_VLD0, RESP_VLD1, RESP_RDY0, RESP_RDY1;
  logic [127:0] KEY0, KEY1, DIN0, DIN1, DOUT, C_KEY, C_DIN;
  logic ERR, C_KRDY, C_DRDY, C_EN_E, C_EN_D, C_BSY_E, C_BSY_D;
  logic C_DVLD_E, C_DVLD_D;
  logic [127:0] C_DOUT_E, C_DOUT_D;

  always #5 CLK = ~CLK;

  aes_job_sched #(.TIMEOUT(TO), .RST_PTR(0)) dut (
    .CLK(CLK), .RST(RST), .REQ0(REQ0), .REQ1(REQ1), .MODE0(MODE0), .MODE1(MODE1),
    .KEY0(KEY0), .KEY1(KEY1), .DIN0(DIN0), .DIN1(DIN1), .GNT0(GNT0), .GNT1(GNT1),
    .RESP_VLD0(RESP_VLD0), .RESP_VLD1(RESP_VLD1), .RESP_RDY0(RESP_RDY0),
    .RESP_RDY1(RESP_RDY1), .DOUT(DOUT), .ERR(ERR), .C_KEY(C_KEY), .C_DIN(C_DIN),
    .C_KRDY(C_KRDY), .C_DRDY(C_DRDY), .C_EN_E(C_EN_E), .C_EN_D(C_EN_D),
    .C_BSY_E(C_BSY_E), .C_BSY_D(C_BSY_D), .C_DVLD_E(C_DVLD_E), .C_DVLD_D(C_DVLD_D),
    .C_DOUT_E(C_DOUT_E), .C_DOUT_D(C_DOUT_D)
  );

  int n_checks = 0, n_pass = 0;
  int cyc = 0, resp_cnt = 0, viol = 0, en_e_cnt = 0, krdy_cnt = 0, gnt1_cnt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Stand-in for the AES cores: real FIPS-197 vectors, otherwise a cheap mix.
  function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k, d);
    if (!m && k == KF && d == PF) return CF;
    if (m && k == KD && d == CF) return PF;
    return m ? ~(d ^ k) : (d ^ {k[63:0], k[127:64]});
  endfunction

  // ---- core pair model ----
  logic hang = 1'b0, spur = 1'b0, bsy_force = 1'b0;
  logic run, bm;
  int cnt;
  logic [127:0] ke, kd, din_m;
  assign C_BSY_E = (run & ~bm) | bsy_force;
  assign C_BSY_D = (run & bm) | bsy_force;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      run <= 1'b0; bm <= 1'b0; cnt <= 0; ke <= '0; kd <= '0; din_m <= '0;
      C_DVLD_E <= 1'b0; C_DVLD_D <= 1'b0; C_DOUT_E <= '0; C_DOUT_D <= '0;
    end else begin
      C_DVLD_E <= 1'b0;
      C_DVLD_D <= 1'b0;
      if (C_KRDY && C_EN_E) ke <= C_KEY;
      if (C_KRDY && C_EN_D) kd <= C_KEY;
      if (C_DRDY && (C_EN_E || C_EN_D)) begin
        run <= 1'b1; bm <= C_EN_D; din_m <= C_DIN; cnt <= LAT;
      end else if (run) begin
        cnt <= cnt - 1;
        if (spur && cnt == 2) begin
          if (bm) begin C_DVLD_E <= 1'b1; C_DOUT_E <= '1; end
          else begin C_DVLD_D <= 1'b1; C_DOUT_D <= '1; end
        end
        if (cnt == 1) begin
          run <= 1'b0;
          if (!hang) begin
            if (bm) begin C_DVLD_D <= 1'b1; C_DOUT_D <= core_fn(1'b1, kd, din_m); end
            else begin C_DVLD_E <= 1'b1; C_DOUT_E <= core_fn(1'b0, ke, din_m); end
          end
        end
      end
    end
  end

  // ---- scoreboard and monitor ----
  typedef struct {int owner; logic [127:0] dout; logic err;} exp_t;
  exp_t sb_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (!RST) begin
      if (GNT0 && GNT1) viol++;
      if (C_EN_E && C_EN_D) viol++;
      if (RESP_VLD0 && RESP_VLD1) viol++;
      if (C_DRDY && (C_BSY_E || C_BSY_D)) viol++;
      if (C_EN_E) en_e_cnt++;
      if (C_KRDY) krdy_cnt++;
      if (GNT1) gnt1_cnt++;
      if ((RESP_VLD0 && RESP_RDY0) || (RESP_VLD1 && RESP_RDY1)) begin
        exp_t e;
        resp_cnt++;
        check("sb_expected_resp", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("resp_owner", RESP_VLD1, e.owner[0]);
          check("resp_dout", DOUT, e.dout);
          check("resp_err", ERR, e.err);
        end
      end
    end
  end

  // sel: 0 GNT0, 1 GNT1, 2 C_DRDY, 3 RESP_VLD0, 5 C_DVLD_E
  task automatic wait_for(input int sel, input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge CLK);
      if ((sel == 0 && GNT0) || (sel == 1 && GNT1) || (sel == 2 && C_DRDY) ||
          (sel == 3 && RESP_VLD0) || (sel == 5 && C_DVLD_E)) begin
        ok = 1;
        break;
      end
    end
    check(name, ok, 1);
  endtask

  task automatic wait_resp(input int target, input int limit, input string name);
    bit ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge CLK);
      if (resp_cnt >= target) begin ok = 1; break; end
    end
    check(name, ok, 1);
  endtask

  task automatic set_req(input int r, input logic m, input logic [127:0] k, d);
    if (r == 0) begin MODE0 = m; KEY0 = k; DIN0 = d; REQ0 = 1'b1; end
    else begin MODE1 = m; KEY1 = k; DIN1 = d; REQ1 = 1'b1; end
  endtask

  task automatic run_job(input int r, input logic m, input logic [127:0] k, d,
                         input logic [127:0] ed, input logic ee, input int stall);
    int base = resp_cnt;
    sb_q.push_back('{owner: r, dout: ed, err: ee});
    bsy_force = (stall > 0);
    set_req(r, m, k, d);
    wait_for(r, 50, "job_gnt");
    @(posedge CLK); #1;
    if (r == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge CLK);
      #1 bsy_force = 1'b0;
    end
    wait_resp(base + 1, 200, "job_resp");
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_ctl"}, {GNT0, GNT1, RESP_VLD0, RESP_VLD1, C_KRDY, C_DRDY, C_EN_E, C_EN_D}, 0);
    check({name, "_dout"}, DOUT, 0);
    check({name, "_err"}, ERR, 0);
    check({name, "_ckey"}, C_KEY, 0);
    check({name, "_cdin"}, C_DIN, 0);
  endtask

  typedef struct {
    int r; logic mode; logic [127:0] key; logic [127:0] din; logic [127:0] dout;
    int stall; logic spur;
  } vec_t;
  vec_t vecs[5];

  initial begin
    #400000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int t, d, base, e0, k0, g1;
    int gcnt[2];
    vecs[0] = '{1, 1'b1, KD, CF, PF, 0, 1'b0};
    vecs[1] = '{1, 1'b0, K2, D2, core_fn(1'b0, K2, D2), 0, 1'b0};
    vecs[2] = '{0, 1'b1, K2, D2, core_fn(1'b1, K2, D2), 3, 1'b0};
    vecs[3] = '{0, 1'b0, D2, K2, core_fn(1'b0, D2, K2), 0, 1'b1};
    vecs[4] = '{1, 1'b1, D2, PF, core_fn(1'b1, D2, PF), 2, 1'b1};

    REQ0 = 0; REQ1 = 0; MODE0 = 0; MODE1 = 0; KEY0 = '0; KEY1 = '0; DIN0 = '0; DIN1 = '0;
    RESP_RDY0 = 1; RESP_RDY1 = 1;
    repeat (3) @(posedge CLK);
    #1 check_reset_outs("por");
    RST = 1'b0;

    // Encrypt on REQ0 with handshake latency checks.
    base = resp_cnt;
    sb_q.push_back('{owner: 0, dout: CF, err: 1'b0});
    set_req(0, 1'b0, KF, PF);
    wait_for(0, 20, "enc_gnt0");
    t = cyc;
    @(posedge CLK); #1 REQ0 = 1'b0;
    check("enc_ckey", C_KEY, KF);
    check("enc_cdin", C_DIN, PF);
    @(negedge CLK);
    check("enc_krdy_t1", {C_KRDY, C_EN_E, C_EN_D}, 3'b110);
    @(negedge CLK);
    check("enc_drdy_t2", C_DRDY, 1);
    check("enc_drdy_cycle", cyc - t, 2);
    wait_for(5, 20, "enc_dvld");
    @(negedge CLK);
    check("enc_vld_after_dvld", RESP_VLD0, 1);
    wait_resp(base + 1, 50, "enc_resp");

    // Table of jobs.
    foreach (vecs[i]) begin
      e0 = en_e_cnt;
      spur = vecs[i].spur;
      run_job(vecs[i].r, vecs[i].mode, vecs[i].key, vecs[i].din, vecs[i].dout, 1'b0,
              vecs[i].stall);
      spur = 1'b0;
      if (vecs[i].mode) check("dec_en_e_low", en_e_cnt - e0, 0);
    end

    // Backpressure: owner 0 holds off, REQ1 waits, RESP_RDY1 is ignored.
    base = resp_cnt;
    RESP_RDY0 = 1'b0;
    sb_q.push_back('{owner: 0, dout: core_fn(1'b0, K2, PF), err: 1'b0});
    sb_q.push_back('{owner: 1, dout: core_fn(1'b1, KF, D2), err: 1'b0});
    set_req(0, 1'b0, K2, PF);
    wait_for(0, 20, "bp_gnt0");
    @(posedge CLK); #1 REQ0 = 1'b0;
    set_req(1, 1'b1, KF, D2);
    wait_for(3, 50, "bp_vld0");
    g1 = gnt1_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("bp_vld_hold", RESP_VLD0, 1);
      check("bp_dout_hold", DOUT, core_fn(1'b0, K2, PF));
    end
    check("bp_no_gnt1", gnt1_cnt - g1, 0);
    @(posedge CLK); #1 RESP_RDY0 = 1'b1;
    wait_for(1, 20, "bp_gnt1");
    @(posedge CLK); #1 REQ1 = 1'b0;
    wait_resp(base + 2, 100, "bp_resp");

    // Timeout: core never raises Dvld.
    base = resp_cnt;
    hang = 1'b1;
    sb_q.push_back('{owner: 0, dout: '0, err: 1'b1});
    set_req(0, 1'b0, D2, D2);
    wait_for(0, 20, "to_gnt");
    @(posedge CLK); #1 REQ0 = 1'b0;
    wait_for(2, 20, "to_drdy");
    d = cyc;
    wait_for(3, 100, "to_vld");
    check("to_latency", cyc - d, TO + 1);
    wait_resp(base + 1, 20, "to_resp");
    hang = 1'b0;

    // Reset mid-WAIT: job dropped, outputs cleared at once, pointer restored.
    sb_q.push_back('{owner: 0, dout: core_fn(1'b0, K2, D2), err: 1'b0});
    set_req(0, 1'b0, K2, D2);
    wait_for(0, 20, "rw_gnt");
    @(posedge CLK); #1 REQ0 = 1'b0;
    wait_for(2, 20, "rw_drdy");
    @(negedge CLK);
    #2 RST = 1'b1;
    #1 check_reset_outs("rst_mid");
    sb_q.delete();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;

    // Both requesters in the first cycle after reset, held: 0,1,0,1.
    base = resp_cnt;
    gcnt[0] = 0; gcnt[1] = 0;
    for (int g = 0; g < 4; g++)
      sb_q.push_back('{owner: g % 2,
                       dout: (g % 2) ? core_fn(1'b1, KD, CF) : core_fn(1'b0, K2, PF),
                       err: 1'b0});
    set_req(0, 1'b0, K2, PF);
    set_req(1, 1'b1, KD, CF);
    for (int g = 0; g < 4; g++) begin
      bit ok = 0;
      int who;
      for (int i = 0; i < 100; i++) begin
        @(negedge CLK);
        if (g == 0 && i == 0) check("rst_drop_no_resp", RESP_VLD0 | RESP_VLD1, 0);
        if (GNT0 || GNT1) begin ok = 1; break; end
      end
      check("alt_gnt_seen", ok, 1);
      who = GNT1 ? 1 : 0;
      check("alt_order", who, g % 2);
      @(posedge CLK); #1;
      gcnt[who]++;
      if (gcnt[who] == 2) begin
        if (who == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    wait_resp(base + 4, 200, "alt_resp");

    // Repeated encrypt job: KEY step skipped only with the key cache.
    run_job(0, 1'b0, KF, PF, CF, 1'b0, 0);
    base = resp_cnt;
    k0 = krdy_cnt;
    sb_q.push_back('{owner: 0, dout: CF, err: 1'b0});
    set_req(0, 1'b0, KF, PF);
    wait_for(0, 20, "rep_gnt");
    @(posedge CLK); #1 REQ0 = 1'b0;
    @(negedge CLK);
`ifdef AES_KEY_CACHE_EN
    check("rep_drdy_t1", {C_DRDY, C_KRDY}, 2'b10);
    wait_resp(base + 1, 50, "rep_resp");
    check("rep_krdy_count", krdy_cnt - k0, 0);
`else
    check("rep_krdy_t1", {C_DRDY, C_KRDY}, 2'b01);
    wait_resp(base + 1, 50, "rep_resp");
    check("rep_krdy_count", krdy_cnt - k0, 1);
`endif

    check("invariants", viol, 0);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
